// File: rtl/wave_gen.sv
// wave_gen: square/pulse/sawtooth/triangle generator whose config changes only at waveform wrap
// Ports:
//   base_freq        clock, all state changes on its rising edge
//   rst_n            asynchronous active-low reset
//   en               run enable; low holds phase and outputs at zero
//   load             strobe capturing mode/period/duty into the pending config
//   mode             0 square, 1 pulse, 2 sawtooth, 3 triangle
//   period           waveform length in clocks (0 = 2^PHASE_W, 1 = 2)
//   duty             pulse-mode high count in clocks
//   wave_out         registered sample, one clock behind the phase it shows
//   wrap             registered marker for the phase-0 sample
module wave_gen #(
  parameter int OUT_W   = 4,
  parameter int PHASE_W = 6
) (
  input  logic               base_freq,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] period,
  input  logic [PHASE_W-1:0] duty,
  output logic [OUT_W-1:0]   wave_out,
  output logic               wrap
);
  logic [1:0]         mode_p, mode_a;
  logic [PHASE_W:0]   n_p, n_a, n_in;
  logic [PHASE_W-1:0] duty_p, duty_a, phase;
  logic [OUT_W-1:0]   f, tri_v;
  logic               last, take;
  // Period is held one bit wider so 2^PHASE_W is representable and wraps correctly
  assign n_in  = period == '0 ? {1'b1, {PHASE_W{1'b0}}}
               : period == PHASE_W'(1) ? (PHASE_W+1)'(2) : {1'b0, period};
  assign last  = {1'b0, phase} == n_a - (PHASE_W+1)'(1);
  // Active config is refreshed only between waveform periods or while idle; a
  // load on that same edge bypasses the pending registers
  assign take  = !en || last;
  assign tri_v = phase[PHASE_W-2 -: OUT_W];
  always_comb
    f = mode_a == 2'd0 ? (({1'b0, phase} < (n_a >> 1)) ? '0 : '1)
      : mode_a == 2'd1 ? ((phase < duty_a) ? '1 : '0)
      : mode_a == 2'd2 ? phase[PHASE_W-1 -: OUT_W]
      : (phase[PHASE_W-1] ? ~tri_v : tri_v);
  always_ff @(posedge base_freq or negedge rst_n)
    if (!rst_n) begin
      mode_p   <= '0;
      mode_a   <= '0;
      n_p      <= (PHASE_W+1)'(32);
      n_a      <= (PHASE_W+1)'(32);
      duty_p   <= PHASE_W'(16);
      duty_a   <= PHASE_W'(16);
      phase    <= '0;
      wave_out <= '0;
      wrap     <= 1'b0;
    end else begin
      if (load) begin
        mode_p <= mode;
        n_p    <= n_in;
        duty_p <= duty;
      end
      if (take) begin
        mode_a <= load ? mode : mode_p;
        n_a    <= load ? n_in : n_p;
        duty_a <= load ? duty : duty_p;
      end
      phase    <= take ? '0 : phase + PHASE_W'(1);
      wave_out <= en ? f : '0;
      wrap     <= en && phase == '0;
    end
endmodule
